// File: rtl/regfile_sequencer_if.sv
// Purpose: bundles the instruction-side and register-file-side signals of the sequencer.
// Ports:   master = sequencer view (drives read/write ports and status);
//          slave  = environment view (instruction source plus register file).
interface regfile_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [7:0]        instr;
  logic [DATA_W-1:0] immData;
  logic [DATA_W-1:0] readData1;
  logic [DATA_W-1:0] readData2;
  logic              readRegister1;
  logic              readRegister2;
  logic              writeEnable;
  logic              writeRegister;
  logic [DATA_W-1:0] writeData;
  logic              busy;
  logic              done;
  logic              zeroFlag;
  logic              carryFlag;

  modport master (
    input  start, instr, immData, readData1, readData2,
    output readRegister1, readRegister2, writeEnable, writeRegister, writeData,
    output busy, done, zeroFlag, carryFlag
  );

  modport slave (
    output start, instr, immData, readData1, readData2,
    input  readRegister1, readRegister2, writeEnable, writeRegister, writeData,
    input  busy, done, zeroFlag, carryFlag
  );
endinterface

// File: rtl/regfile_sequencer.sv
// Purpose: multi-cycle controller running one 8-bit micro-instruction against a 2x DATA_W register file.
// Latency: done in cycle k+READ_WAIT+3 after start at edge k (NOP: k+READ_WAIT+2); start ignored while busy.
// Ports:   clk, rst_n (async active-low), bus (regfile_sequencer_if.master); with macro
//          REGSEQ_PERF_CNT_EN defined, also instrCount/writeCount performance counters.
module regfile_sequencer #(
  parameter int DATA_W    = 8,
  parameter int READ_WAIT = 1   // legal range 1..15 (4-bit wait counter)
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_sequencer_if.master bus
`ifdef REGSEQ_PERF_CNT_EN
  ,
  output logic [15:0]         instrCount,
  output logic [15:0]         writeCount
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WB, S_DONE} state_t;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_LDI = 3'b111;

  localparam logic [3:0] WAIT_LAST = 4'(READ_WAIT - 1);

  state_t            state_q;
  logic [7:0]        instr_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] result_q;
  logic [3:0]        wait_q;
  logic              rr1_q, rr2_q, we_q, wr_q, busy_q, done_q, zero_q, carry_q;

  logic [2:0]        op;
  logic [DATA_W-1:0] result_d;
  logic              carry_d;
  logic [DATA_W:0]   sum, diff;

  assign op = instr_q[7:5];

  // ALU evaluated from the live register-file outputs; only sampled at the end of EXEC.
  always_comb begin
    sum      = {1'b0, bus.readData1} + {1'b0, bus.readData2};
    diff     = {1'b0, bus.readData1} - {1'b0, bus.readData2};
    result_d = result_q;
    carry_d  = carry_q;
    case (op)
      OP_ADD: begin result_d = sum[DATA_W-1:0];  carry_d = sum[DATA_W];  end
      // The extra MSB of the zero-extended difference is the borrow (rs1 < rs2).
      OP_SUB: begin result_d = diff[DATA_W-1:0]; carry_d = diff[DATA_W]; end
      OP_AND: begin result_d = bus.readData1 & bus.readData2; carry_d = 1'b0; end
      OP_OR:  begin result_d = bus.readData1 | bus.readData2; carry_d = 1'b0; end
      OP_XOR: begin result_d = bus.readData1 ^ bus.readData2; carry_d = 1'b0; end
      OP_MOV: result_d = bus.readData1;
      OP_LDI: result_d = imm_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      imm_q    <= '0;
      result_q <= '0;
      wait_q   <= '0;
      rr1_q    <= 1'b0;
      rr2_q    <= 1'b0;
      we_q     <= 1'b0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      we_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            instr_q <= bus.instr;
            imm_q   <= bus.immData;
            // Read addresses go out straight from the incoming word so READ sees them immediately.
            rr1_q   <= bus.instr[3];
            rr2_q   <= bus.instr[2];
            busy_q  <= 1'b1;
            wait_q  <= '0;
            state_q <= S_READ;
          end
        end
        S_READ: begin
          if (wait_q == WAIT_LAST) state_q <= S_EXEC;
          else                     wait_q  <= wait_q + 4'd1;
        end
        S_EXEC: begin
          if (op == OP_NOP) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= (result_d == '0);
            we_q     <= 1'b1;
            wr_q     <= instr_q[4];
            state_q  <= S_WB;
          end
        end
        S_WB: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.readRegister1 = rr1_q;
  assign bus.readRegister2 = rr2_q;
  assign bus.writeEnable   = we_q;
  assign bus.writeRegister = wr_q;
  assign bus.writeData     = result_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.zeroFlag      = zero_q;
  assign bus.carryFlag     = carry_q;

`ifdef REGSEQ_PERF_CNT_EN
  logic [15:0] instr_cnt_q, write_cnt_q;

  // instrCount steps on the edge that raises done, so it moves together with the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt_q <= '0;
      write_cnt_q <= '0;
    end else begin
      if (state_q == S_WB || (state_q == S_EXEC && op == OP_NOP))
        instr_cnt_q <= instr_cnt_q + 16'd1;
      if (state_q == S_WB)
        write_cnt_q <= write_cnt_q + 16'd1;
    end
  end

  assign instrCount = instr_cnt_q;
  assign writeCount = write_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_sequencer.sv
module tb_regfile_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_sequencer_if #(.DATA_W(8)) bus ();

`ifdef REGSEQ_PERF_CNT_EN
  logic [15:0] instrCount, writeCount;
`endif

  regfile_sequencer #(.DATA_W(8), .READ_WAIT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
`ifdef REGSEQ_PERF_CNT_EN
    ,
    .instrCount (instrCount),
    .writeCount (writeCount)
`endif
  );

  // Register file model: combinational reads, write on rising edge.
  logic [7:0] rf [2];
  assign bus.readData1 = rf[bus.readRegister1];
  assign bus.readData2 = rf[bus.readRegister2];
  always @(posedge clk) if (bus.writeEnable) rf[bus.writeRegister] <= bus.writeData;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] op;
    logic       rd, rs1, rs2;
    logic [7:0] imm;
    logic       exp_wreg;
    logic [7:0] exp_wd;
    logic       exp_z, exp_c;
  } vec_t;

  vec_t vecs[$];

  // Issues one instruction and observes a fixed window after the accepting edge k.
  // lat / wcyc are reported as spec cycle numbers relative to k (sample after edge k+n = cycle k+n+1).
  task automatic run(input logic [2:0] op, input logic rd, input logic rs1, input logic rs2,
                     input logic [7:0] imm, input bit pulse,
                     output int lat, output int wcyc, output int nwr, output int ndone,
                     output logic busy0, output logic wreg, output logic [7:0] wd);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.instr   = {op, rd, rs1, rs2, 2'b00};
    bus.immData = imm;
    @(posedge clk);
    lat = 0; wcyc = 0; nwr = 0; ndone = 0; busy0 = 1'b0; wreg = 1'b0; wd = 8'h00;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (n == 0) busy0 = bus.busy;
      if (bus.writeEnable) begin
        nwr++;
        wcyc = n + 1;
        wreg = bus.writeRegister;
        wd   = bus.writeData;
      end
      if (bus.done) begin
        ndone++;
        if (lat == 0) lat = n + 1;
      end
      bus.start = pulse && (n < 2);
    end
  endtask

  int lat, wcyc, nwr, ndone;
  logic busy0, wreg;
  logic [7:0] wd;

  initial begin
    bus.start = 1'b0; bus.instr = 8'h00; bus.immData = 8'h00;
    rf[0] = 8'h04; rf[1] = 8'h05;

    //                op     rd    rs1   rs2   imm    wreg  wd     z     c
    vecs.push_back('{3'd1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h09, 1'b0, 1'b0}); // ADD r0=4+5
    vecs.push_back('{3'd7, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b1, 8'hFF, 1'b0, 1'b0}); // LDI r1=FF
    vecs.push_back('{3'd1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b1}); // ADD FF+FF
    vecs.push_back('{3'd7, 1'b0, 1'b0, 1'b0, 8'h04, 1'b0, 8'h04, 1'b0, 1'b1}); // LDI keeps carry
    vecs.push_back('{3'd2, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0}); // SUB 4-4
    vecs.push_back('{3'd7, 1'b0, 1'b0, 1'b0, 8'h04, 1'b0, 8'h04, 1'b0, 1'b0}); // LDI r0=4
    vecs.push_back('{3'd7, 1'b1, 1'b0, 1'b0, 8'h05, 1'b1, 8'h05, 1'b0, 1'b0}); // LDI r1=5
    vecs.push_back('{3'd2, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b1}); // SUB 4-5 borrow
    vecs.push_back('{3'd3, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 8'h05, 1'b0, 1'b0}); // AND FF&05
    vecs.push_back('{3'd5, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0}); // XOR 5^5
    vecs.push_back('{3'd4, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h05, 1'b0, 1'b0}); // OR 0|5
    vecs.push_back('{3'd7, 1'b1, 1'b0, 1'b0, 8'h10, 1'b1, 8'h10, 1'b0, 1'b0}); // LDI r1=10
    vecs.push_back('{3'd2, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'hF5, 1'b0, 1'b1}); // SUB 05-10
    vecs.push_back('{3'd6, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'hF5, 1'b0, 1'b1}); // MOV keeps carry

    // Reset state.
    #12;
    chk("reset_outputs",
        {bus.busy, bus.done, bus.writeEnable, bus.writeRegister, bus.readRegister1,
         bus.readRegister2, bus.zeroFlag, bus.carryFlag, bus.writeData}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("idle_not_busy", bus.busy, 1'b0);

    foreach (vecs[i]) begin
      run(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, 1'b0,
          lat, wcyc, nwr, ndone, busy0, wreg, wd);
      chk($sformatf("v%0d_busy", i), busy0, 1'b1);
      chk($sformatf("v%0d_done_cycle", i), lat, 4);
      chk($sformatf("v%0d_done_count", i), ndone, 1);
      chk($sformatf("v%0d_write_count", i), nwr, 1);
      chk($sformatf("v%0d_write_cycle", i), wcyc, 3);
      chk($sformatf("v%0d_wreg", i), wreg, vecs[i].exp_wreg);
      chk($sformatf("v%0d_wdata", i), wd, vecs[i].exp_wd);
      chk($sformatf("v%0d_zero", i), bus.zeroFlag, vecs[i].exp_z);
      chk($sformatf("v%0d_carry", i), bus.carryFlag, vecs[i].exp_c);
      chk($sformatf("v%0d_rf", i), rf[vecs[i].exp_wreg], vecs[i].exp_wd);
      chk($sformatf("v%0d_idle", i), bus.busy, 1'b0);
    end
    chk("first_add_r0_after_chain", rf[0], 8'hF5);

    // NOP with start re-pulsed during READ/EXEC: exactly one instruction, no write.
    run(3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, lat, wcyc, nwr, ndone, busy0, wreg, wd);
    chk("nop_done_cycle", lat, 3);
    chk("nop_done_count", ndone, 1);
    chk("nop_no_write", nwr, 0);
    chk("nop_zero_kept", bus.zeroFlag, 1'b0);
    chk("nop_carry_kept", bus.carryFlag, 1'b1);
    chk("nop_wdata_held", bus.writeData, 8'hF5);
    chk("nop_rf", {rf[0], rf[1]}, 16'hF5F5);

    run(3'd7, 1'b1, 1'b0, 1'b0, 8'h77, 1'b0, lat, wcyc, nwr, ndone, busy0, wreg, wd);
    chk("ldi77_rf1", rf[1], 8'h77);

    // Reset asserted in the WB cycle of MOV r1<=r0: the write must not land.
    @(negedge clk);
    bus.start = 1'b1; bus.instr = {3'd6, 1'b1, 1'b0, 1'b0, 2'b00}; bus.immData = 8'h00;
    @(posedge clk);
    @(negedge clk); bus.start = 1'b0;
    begin
      int guard = 0;
      while (!bus.writeEnable && guard < 10) begin @(negedge clk); guard++; end
      chk("mov_reached_wb", bus.writeEnable, 1'b1);
    end
    rst_n = 1'b0;
    #1;
    chk("rst_in_wb_outputs",
        {bus.busy, bus.done, bus.writeEnable, bus.writeRegister, bus.readRegister1,
         bus.readRegister2, bus.zeroFlag, bus.carryFlag, bus.writeData}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_wb_r1_kept", rf[1], 8'h77);
    rst_n = 1'b1;

    run(3'd7, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, lat, wcyc, nwr, ndone, busy0, wreg, wd);
    chk("post_rst_ldi_done", lat, 4);
    chk("post_rst_ldi_wdata", wd, 8'h3C);
    chk("post_rst_ldi_rf0", rf[0], 8'h3C);

`ifdef REGSEQ_PERF_CNT_EN
    run(3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, lat, wcyc, nwr, ndone, busy0, wreg, wd);
    run(3'd1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, lat, wcyc, nwr, ndone, busy0, wreg, wd);
    chk("perf_instr_count", instrCount, 16'd3);
    chk("perf_write_count", writeCount, 16'd2);
    @(negedge clk);
    force dut.instr_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.instr_cnt_q;
    run(3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, lat, wcyc, nwr, ndone, busy0, wreg, wd);
    chk("perf_instr_wrap", instrCount, 16'h0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Multi-cycle controller that executes one 8-bit micro-instruction at a time against the 2-entry x 8-bit register file.
- Accepts an instruction on a start strobe, then drives the read address, ALU, and write-back sequence.
- Holds the write port under its exclusive control.
- Sits between the instruction source (testbench or fetch unit) and the register file; it has no storage other than its own pipeline registers and flags.

Parameters:
- DATA_W, 8, datapath width; must match the register file width.
- READ_WAIT, 1, cycles spent in READ before operands are sampled; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  instruction strobe; sampled only in IDLE.
- instr  input  8  instruction word: [7:5] op, [4] rd, [3] rs1, [2] rs2, [1:0] reserved (ignored).
- immData  input  DATA_W  immediate operand for LDI; sampled together with instr.
- readData1  input  DATA_W  register file Out1.
- readData2  input  DATA_W  register file Out2.
- readRegister1  output  1  register file read address 1.
- readRegister2  output  1  register file read address 2.
- writeEnable  output  1  register file write enable.
- writeRegister  output  1  register file write address.
- writeData  output  DATA_W  register file write data.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle completion pulse.
- zeroFlag  output  1  result == 0 for the last flag-updating op.
- carryFlag  output  1  carry/borrow of the last arithmetic op.

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0; latched instr/imm/result 0. Reset mid-operation drops writeEnable immediately, so no write occurs.
- Op encoding: 000 NOP, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 MOV (rd<=rs1), 111 LDI (rd<=immData).
- States: IDLE, READ, EXEC, WB, DONE.
- IDLE:
  - start=1 at edge k latches instr and immData; next state READ; busy=1.
  - start is ignored in every other state.
- READ:
  - readRegister1=rs1 and readRegister2=rs2 are driven from the latched instr for READ_WAIT cycles (internal counter).
  - Leaves READ after the last wait cycle.
- EXEC (1 cycle):
  - At the end edge, samples readData1/readData2 and registers the DATA_W-bit result.
  - ADD: carry=carry-out of the DATA_W+1 sum.
  - SUB: rs1-rs2 with carry=borrow (1 when rs1<rs2); results wrap modulo 2^DATA_W.
  - AND/OR/XOR: carry cleared to 0.
  - MOV/LDI: carry unchanged.
  - zeroFlag is updated for all ops except NOP; NOP leaves both flags unchanged.
  - Next state: WB; NOP goes to DONE.
- WB (1 cycle): writeEnable=1, writeRegister=rd, writeData=result. The register file captures at the end edge. Next state: DONE.
- DONE (1 cycle): done=1, busy=0, writeEnable=0. Next state IDLE; a start presented in this cycle is not accepted until IDLE.
- Timing: start sampled at edge k.
  - ALU, MOV and LDI ops: done is high in cycle k+READ_WAIT+3; writeEnable is high in cycle k+READ_WAIT+2.
  - NOP: done is high in cycle k+READ_WAIT+2; no write.
- Output stability:
  - writeEnable is high only in WB.
  - writeRegister and writeData are held at their last values outside WB.
  - Read addresses hold their last values outside READ/EXEC.
- rd==rs1 is legal: the operand is sampled before write-back, with no hazard.

Optional Feature:
- Macro REGSEQ_PERF_CNT_EN.
- Defined:
  - Adds output instrCount [15:0], which increments on every done pulse (including NOP) and wraps 0xFFFF->0x0000.
  - Adds output writeCount [15:0], which increments in every WB cycle.
  - Both counters reset to 0 on rst_n.
- Undefined: both ports and both counters are absent; all other behaviour is identical.

Test Plan:
- Register model r0=0x04, r1=0x05, READ_WAIT=1; ADD rd=0 rs1=0 rs2=1 -> writeEnable one cycle with writeRegister=0 and writeData=0x09; done at k+4; zero=0, carry=0; r0=0x09.
- LDI rd=1 imm=0xFF, then ADD rd=1 rs1=1 rs2=1 -> writeData=0xFE, carry=1, zero=0.
- SUB rd=0 rs1=0 rs2=0 with r0=0x04 -> writeData=0x00, zero=1, carry=0; then SUB with r0=0x04 and r1=0x05 -> 0xFF, carry=1.
- NOP with start also pulsed during READ/EXEC -> no writeEnable, flags unchanged, done at k+3, exactly one instruction executed.
- Drop rst_n low during the WB cycle of MOV rd=1 rs1=0 -> writeEnable falls immediately, r1 is unchanged, all outputs are 0; a new LDI after reset completes normally.
- REGSEQ_PERF_CNT_EN defined: run 3 ops including 1 NOP -> instrCount=3, writeCount=2; preload instrCount=0xFFFF via 65535 ops (or force), then one more op -> 0x0000.
